// File: rtl/jesd204_tx_pkg.sv
// Shared constants, state encoding and ILAS octet generation for the
// JESD204B link-layer transmitter.
package jesd204_tx_pkg;

  // Control characters, pre-8b10b encoding
  localparam logic [7:0] K28_5 = 8'hBC;  // /K/ comma, CGS filler
  localparam logic [7:0] K28_0 = 8'h1C;  // /R/ multiframe start
  localparam logic [7:0] K28_3 = 8'h7C;  // /A/ multiframe end
  localparam logic [7:0] K28_4 = 8'h9C;  // /Q/ config data follows

  localparam int CFG_OCTETS = 14;

  typedef enum logic [1:0] {
    LS_IDLE = 2'd0,
    LS_CGS  = 2'd1,
    LS_ILAS = 2'd2,
    LS_DATA = 2'd3
  } link_state_e;

  // One ILAS octet: mf = multiframe index, o = octet index within the
  // multiframe, fk = octets per multiframe. Returns {k, data}.
  function automatic logic [8:0] ilas_octet(input logic [7:0] mf,
                                            input logic [15:0] o,
                                            input logic [15:0] fk,
                                            input logic [8*CFG_OCTETS-1:0] cfg);
    logic [8:0] r;
    r = {1'b0, o[7:0]};
    if (o == 16'd0) begin
      r = {1'b1, K28_0};
    end else if (o == fk - 16'd1) begin
      r = {1'b1, K28_3};
    end else if (mf == 8'd1) begin
      if (o == 16'd1) begin
        r = {1'b1, K28_4};
      end else begin
        // The link configuration rides in octets 2..15 of the second multiframe
        for (int j = 0; j < CFG_OCTETS; j++) begin
          if (o == 16'(j + 2)) r = {1'b0, cfg[8*j +: 8]};
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/jesd204_tx_link_if.sv
// User-data and GT-side bus of the JESD204B transmit link.
// master = the link block, slave = whatever feeds it and observes the GT stream.
interface jesd204_tx_link_if #(
  parameter int LANES = 8
);
  logic [LANES*32-1:0] tx_data;
  logic                tx_ready;
  logic [LANES*32-1:0] gt_data;
  logic [LANES*4-1:0]  gt_charisk;

  modport master (
    input  tx_data,
    output tx_ready,
    output gt_data,
    output gt_charisk
  );

  modport slave (
    output tx_data,
    input  tx_ready,
    input  gt_data,
    input  gt_charisk
  );
endinterface

// File: rtl/jesd204_tx_lmfc.sv
// Local multiframe clock counter. SYSREF rising edges re-phase the counter
// only while align_en is high; otherwise it free-runs modulo CPM.
module jesd204_tx_lmfc #(
  parameter int CPM = 16,
  parameter int CW  = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          sysref,
  input  logic          align_en,
  output logic [CW-1:0] lmfc_cnt,
  output logic          lmfc_pulse,
  output logic          align_load
);

  localparam logic [CW-1:0] CNT_LAST = CW'(CPM - 1);

  logic          sysref_d;
  logic [CW-1:0] cnt_next;

  assign align_load = align_en & sysref & ~sysref_d;

  // Next count: SYSREF alignment load, else wrap at the multiframe end
  always_comb begin
    cnt_next = lmfc_cnt + CW'(1);
    if (align_load || lmfc_cnt == CNT_LAST) cnt_next = '0;
  end

  // Count, boundary pulse and SYSREF history registered together
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sysref_d   <= 1'b0;
      lmfc_cnt   <= '0;
      lmfc_pulse <= 1'b0;
    end else begin
      sysref_d   <= sysref;
      lmfc_cnt   <= cnt_next;
      lmfc_pulse <= (cnt_next == '0);
    end
  end

endmodule

// File: rtl/jesd204_tx_link.sv
// JESD204B link-layer transmitter: CGS -> ILAS -> user data per lane,
// producing pre-8b10b octets and K flags for the GT transceivers.
module jesd204_tx_link
  import jesd204_tx_pkg::*;
#(
  parameter int LANES   = 8,
  parameter int F       = 2,
  parameter int K       = 32,
  parameter int ILAS_MF = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 link_en,
  input  logic                 sysref,
  input  logic                 sync_n,
  input  logic [LANES*112-1:0] cfg_ilas,
  output logic                 lmfc_pulse,
  output logic [1:0]           link_state,
  jesd204_tx_link_if.master    bus
);

  localparam int CPM = F * K / 4;
  localparam int CW  = (CPM > 1) ? $clog2(CPM) : 1;
  localparam int MFW = (ILAS_MF > 1) ? $clog2(ILAS_MF) : 1;

  localparam logic [1:0] ST_IDLE = LS_IDLE;
  localparam logic [1:0] ST_CGS  = LS_CGS;
  localparam logic [1:0] ST_ILAS = LS_ILAS;
  localparam logic [1:0] ST_DATA = LS_DATA;

  localparam logic [CW-1:0]  LMFC_LAST = CW'(CPM - 1);
  localparam logic [MFW-1:0] MF_LAST   = MFW'(ILAS_MF - 1);

  logic           sync_meta_reg, sync_s_reg, sync_low_reg;
  logic [1:0]     state_reg, state_next;
  logic [MFW-1:0] mf_reg, mf_next;
  logic           tx_ready_reg;
  logic [CW-1:0]  lmfc_cnt;
  logic           align_en, align_load, lmfc_last, sync_lost;

  assign align_en   = (state_reg == ST_IDLE) || (state_reg == ST_CGS);
  assign lmfc_last  = (lmfc_cnt == LMFC_LAST);
  // A single low cycle on SYNC~ is a glitch; two in a row is a resync request
  assign sync_lost  = ~sync_s_reg & sync_low_reg;
  assign link_state = state_reg;
  assign bus.tx_ready = tx_ready_reg;

  jesd204_tx_lmfc #(
    .CPM (CPM),
    .CW  (CW)
  ) u_lmfc (
    .clk        (clk),
    .rstn       (rstn),
    .sysref     (sysref),
    .align_en   (align_en),
    .lmfc_cnt   (lmfc_cnt),
    .lmfc_pulse (lmfc_pulse),
    .align_load (align_load)
  );

  // Two-flop synchronizer for the DAC's SYNC~; resets to "sync requested"
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_meta_reg <= 1'b0;
      sync_s_reg    <= 1'b0;
    end else begin
      sync_meta_reg <= sync_n;
      sync_s_reg    <= sync_meta_reg;
    end
  end

  // Link sequencing; a SYSREF re-alignment in CGS defers the ILAS start
  always_comb begin
    state_next = state_reg;
    mf_next    = mf_reg;
    if (!link_en) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: state_next = ST_CGS;
        ST_CGS: begin
          if (sync_s_reg && lmfc_last && !align_load) begin
            state_next = ST_ILAS;
            mf_next    = '0;
          end
        end
        default: begin
          if (sync_lost) begin
            state_next = ST_CGS;
          end else if (state_reg == ST_ILAS && lmfc_last) begin
            if (mf_reg == MF_LAST) state_next = ST_DATA;
            else                   mf_next    = mf_reg + MFW'(1);
          end
        end
      endcase
    end
  end

  // State, multiframe count, SYNC~ history and the data-accept strobe
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg    <= ST_IDLE;
      mf_reg       <= '0;
      sync_low_reg <= 1'b0;
      tx_ready_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      mf_reg       <= mf_next;
      sync_low_reg <= ~sync_s_reg;
      tx_ready_reg <= (state_next == ST_DATA);
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [31:0]  data_next, data_reg;
    logic [3:0]   k_next, k_reg;
    logic [111:0] cfg_lane;
    logic [8:0]   ilas_oct [4];

    assign cfg_lane = cfg_ilas[gi*112 +: 112];

    // Octet index within the multiframe is 4*lmfc_cnt + byte position
    for (genvar gj = 0; gj < 4; gj++) begin : g_oct
      assign ilas_oct[gj] = ilas_octet(8'(mf_reg), 16'({lmfc_cnt, 2'(gj)}),
                                       16'(F * K), cfg_lane);
    end

    // Per-lane octet content selected by the current link state
    always_comb begin
      data_next = {4{K28_5}};
      k_next    = 4'hF;
      case (state_reg)
        ST_ILAS: begin
          for (int i = 0; i < 4; i++) begin
            data_next[8*i +: 8] = ilas_oct[i][7:0];
            k_next[i]           = ilas_oct[i][8];
          end
        end
        ST_DATA: begin
          data_next = bus.tx_data[gi*32 +: 32];
          k_next    = 4'h0;
        end
        default: ;
      endcase
    end

    // Output register towards the GT
    always_ff @(posedge clk) begin
      if (!rstn) begin
        data_reg <= '0;
        k_reg    <= '0;
      end else begin
        data_reg <= data_next;
        k_reg    <= k_next;
      end
    end

    assign bus.gt_data[gi*32 +: 32]   = data_reg;
    assign bus.gt_charisk[gi*4 +: 4]  = k_reg;
  end

endmodule

// File: tb/tb_jesd204_tx_link.sv
// Self-checking bench for jesd204_tx_link: cycle model of the link rules
// compared every cycle, plus literal expectations at key points.
module tb_jesd204_tx_link;

  localparam int LANES     = 8;
  localparam int F         = 2;
  localparam int K         = 32;
  localparam int ILAS_MF   = 4;
  localparam int CPM       = F * K / 4;
  localparam int ILAS_CLKS = ILAS_MF * CPM;
  localparam int DW        = LANES * 32;

  logic clk = 1'b0;
  logic rstn = 1'b0, link_en = 1'b0, sysref = 1'b0, sync_n = 1'b0;
  logic [LANES*112-1:0] cfg_ilas;
  logic                 lmfc_pulse;
  logic [1:0]           link_state;

  jesd204_tx_link_if #(.LANES(LANES)) bus();

  jesd204_tx_link #(.LANES(LANES), .F(F), .K(K), .ILAS_MF(ILAS_MF)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .link_en    (link_en),
    .sysref     (sysref),
    .sync_n     (sync_n),
    .cfg_ilas   (cfg_ilas),
    .lmfc_pulse (lmfc_pulse),
    .link_state (link_state),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  logic [7:0] cfg_b [LANES][14];
  bit chk_en = 1'b0, rand_data = 1'b0;
  int seq = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Expected ILAS octet from the clock index c counted since ILAS start
  function automatic logic [8:0] exp_ilas(input int c, input int i, input int lane);
    int pos, mf;
    pos = (c % CPM) * 4 + i;
    mf  = c / CPM;
    if (pos == 0) return 9'h11C;
    if (pos == F * K - 1) return 9'h17C;
    if (mf == 1 && pos == 1) return 9'h19C;
    if (mf == 1 && pos >= 2 && pos <= 15) return {1'b0, cfg_b[lane][pos-2]};
    return {1'b0, 8'(pos)};
  endfunction

  // Reference model (states: 0 idle, 1 cgs, 2 ilas, 3 data)
  logic [DW-1:0]      e_gt;
  logic [LANES*4-1:0] e_k;
  logic               e_ready, e_pulse;
  logic [1:0]         e_state;
  int m_state, m_lmfc, m_ilas, ns, nl;
  bit m_meta, m_sync, m_low, m_sref, edge_s;
  logic [8:0] oct;

  always @(posedge clk) begin
    if (!rstn) begin
      m_meta = 0; m_sync = 0; m_low = 0; m_sref = 0;
      m_lmfc = 0; m_state = 0; m_ilas = 0;
      e_gt = '0; e_k = '0; e_ready = 0; e_pulse = 0; e_state = 2'd0;
    end else begin
      edge_s = sysref && !m_sref;
      nl = ((m_state <= 1) && edge_s) ? 0 : (m_lmfc + 1) % CPM;
      ns = m_state;
      if (!link_en) ns = 0;
      else if (m_state == 0) ns = 1;
      else if (m_state == 1) begin
        if (m_sync && m_lmfc == CPM - 1 && !edge_s) ns = 2;
      end else if (!m_sync && m_low) ns = 1;
      else if (m_state == 2 && m_ilas == ILAS_CLKS - 1) ns = 3;
      for (int l = 0; l < LANES; l++) begin
        for (int i = 0; i < 4; i++) begin
          if (m_state == 2) oct = exp_ilas(m_ilas, i, l);
          else if (m_state == 3) oct = {1'b0, bus.tx_data[l*32 + i*8 +: 8]};
          else oct = 9'h1BC;
          e_gt[l*32 + i*8 +: 8] = oct[7:0];
          e_k[l*4 + i] = oct[8];
        end
      end
      e_ready = (ns == 3);
      m_low   = !m_sync;
      m_sync  = m_meta;
      m_meta  = sync_n;
      m_sref  = sysref;
      m_lmfc  = nl;
      e_pulse = (nl == 0);
      m_ilas  = (ns == 2 && m_state == 2) ? m_ilas + 1 : 0;
      m_state = ns;
      e_state = 2'(ns);
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("state", link_state, e_state);
      check("lmfc_pulse", lmfc_pulse, e_pulse);
      check("tx_ready", bus.tx_ready, e_ready);
      check("gt_data", bus.gt_data, e_gt);
      check("gt_charisk", bus.gt_charisk, e_k);
    end
  end

  task automatic tick();
    @(negedge clk);
    seq++;
    for (int l = 0; l < LANES; l++)
      bus.tx_data[l*32 +: 32] = rand_data ? $urandom : 32'(seq * LANES + l);
  endtask

  task automatic wait_state(input logic [1:0] s, input int lim, input string nm);
    int n;
    n = 0;
    while (link_state !== s && n < lim) begin
      tick();
      n++;
    end
    check(nm, link_state, s);
  endtask

  task automatic force_cgs();
    sync_n = 1'b0;
    repeat (3) tick();
    sync_n = 1'b1;
    wait_state(2'd1, 10, "resync_cgs");
  endtask

  logic [DW-1:0] saved;
  int n, lo_cnt;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int l = 0; l < LANES; l++)
      for (int j = 0; j < 14; j++) begin
        cfg_b[l][j] = 8'($urandom);
        cfg_ilas[(l*14 + j)*8 +: 8] = cfg_b[l][j];
      end
    bus.tx_data = '0;
    @(posedge clk);
    chk_en = 1'b1;
    repeat (3) tick();
    check("reset_gt", bus.gt_data, '0);
    check("reset_state", link_state, 2'd0);
    check("reset_ready", bus.tx_ready, 1'b0);

    rstn = 1'b1; link_en = 1'b1;
    repeat (3) tick();
    check("cgs_state", link_state, 2'd1);
    check("cgs_gt", bus.gt_data, {LANES*4{8'hBC}});
    check("cgs_k", bus.gt_charisk, {LANES*4{1'b1}});
    check("cgs_ready", bus.tx_ready, 1'b0);

    // Align, release SYNC~, walk through ILAS into DATA
    repeat (3) tick();
    sysref = 1'b1; tick(); sysref = 1'b0;
    repeat (5) tick();
    sync_n = 1'b1;
    wait_state(2'd2, 100, "enter_ilas");
    check("ilas_on_lmfc", lmfc_pulse, 1'b1);
    tick();
    check("ilas_mf0_c0", bus.gt_data[31:0], 32'h0302011C);
    check("ilas_mf0_c0_k", bus.gt_charisk[3:0], 4'b0001);
    repeat (15) tick();
    check("ilas_mf0_end", bus.gt_data[31:0], 32'h7C3E3D3C);
    check("ilas_mf0_end_k", bus.gt_charisk[3:0], 4'b1000);
    tick();
    check("ilas_mf1_c0", bus.gt_data[31:0], {cfg_b[0][1], cfg_b[0][0], 8'h9C, 8'h1C});
    check("ilas_mf1_c0_k", bus.gt_charisk[3:0], 4'b0011);
    repeat (46) tick();
    check("ilas_last_ready", bus.tx_ready, 1'b0);
    tick();
    check("data_ready", bus.tx_ready, 1'b1);
    check("data_state", link_state, 2'd3);
    saved = bus.tx_data;
    tick();
    check("first_data", bus.gt_data, saved);
    check("first_data_k", bus.gt_charisk, '0);
    repeat (30) tick();

    // One-cycle SYNC~ glitch is ignored; two cycles resync
    sync_n = 1'b0; tick(); sync_n = 1'b1;
    repeat (5) tick();
    check("glitch_ignored", link_state, 2'd3);
    sync_n = 1'b0; repeat (2) tick(); sync_n = 1'b1;
    wait_state(2'd1, 10, "sync_loss_cgs");
    check("sync_loss_ready", bus.tx_ready, 1'b0);
    tick();
    check("sync_loss_bc", bus.gt_data, {LANES*4{8'hBC}});
    wait_state(2'd3, 200, "reenter_data");

    // SYSREF at lmfc_cnt 7 during DATA must not move the LMFC
    n = 0;
    while (!lmfc_pulse && n < 40) begin tick(); n++; end
    check("pulse_seen", lmfc_pulse, 1'b1);
    repeat (7) tick();
    sysref = 1'b1; tick(); sysref = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!lmfc_pulse && n < 40);
    check("pulse_after_sysref", 32'(n), 32'd8);
    n = 0;
    do begin tick(); n++; end while (!lmfc_pulse && n < 40);
    check("pulse_period", 32'(n), 32'd16);

    // Randomized traffic, SYNC~ drops, SYSREF pulses and link_en dips
    rand_data = 1'b1;
    lo_cnt = 0;
    for (int c = 0; c < 2500; c++) begin
      if (lo_cnt > 0) begin sync_n = 1'b0; lo_cnt--; end
      else begin
        sync_n = 1'b1;
        if ($urandom_range(0, 199) == 0) lo_cnt = $urandom_range(1, 3);
      end
      sysref  = ($urandom_range(0, 63) == 0);
      link_en = ($urandom_range(0, 999) != 0);
      tick();
    end
    rand_data = 1'b0; sysref = 1'b0; sync_n = 1'b1; link_en = 1'b1;
    wait_state(2'd3, 300, "random_settle_data");

    // link_en drop mid-ILAS, then re-enable
    force_cgs();
    wait_state(2'd2, 100, "ilas_again");
    repeat (10) tick();
    link_en = 1'b0; tick();
    check("disable_idle", link_state, 2'd0);
    link_en = 1'b1; tick();
    check("reenable_cgs", link_state, 2'd1);
    wait_state(2'd2, 100, "reenable_ilas");
    check("reenable_ilas_lmfc", lmfc_pulse, 1'b1);

    // Reset mid-DATA
    wait_state(2'd3, 200, "data_before_reset");
    repeat (5) tick();
    rstn = 1'b0; tick();
    check("midreset_gt", bus.gt_data, '0);
    check("midreset_state", link_state, 2'd0);
    check("midreset_ready", bus.tx_ready, 1'b0);
    tick();
    rstn = 1'b1; tick();
    check("post_reset_cgs", link_state, 2'd1);
    check("post_reset_bc", bus.gt_data, {LANES*4{8'hBC}});
    repeat (3) tick();

    // SYSREF edge coinciding with the CGS->ILAS condition
    link_en = 1'b0; repeat (2) tick();
    sysref = 1'b1; tick();
    sysref = 1'b0; link_en = 1'b1;
    repeat (15) tick();
    check("collide_pre", link_state, 2'd1);
    sysref = 1'b1; tick(); sysref = 1'b0;
    check("collide_held", link_state, 2'd1);
    repeat (15) tick();
    check("collide_wait", link_state, 2'd1);
    tick();
    check("collide_ilas", link_state, 2'd2);
    check("collide_ilas_lmfc", lmfc_pulse, 1'b1);
    repeat (5) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
